cache_fill_fsm: RTL and testbench

//  Miss-handling engine upstream of the memory/cache interface. Accepts a miss (miss_detected,

---
 rtl/cache_fill_fsm_pkg.sv | 25 ++
 rtl/cache_fill_fsm_dff.sv | 38 +++
 rtl/cache_fill_fsm_fill_counter.sv | 40 ++++
 rtl/cache_fill_fsm.sv | 154 +++++++++++++++
 tb/tb_cache_fill_fsm.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// ============================================================================
// Package : cache_fill_fsm_pkg
// Purpose : Shared block-geometry constants and the fill-engine state encoding
//           for the cache miss fill engine and its sub-cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_fill_fsm_pkg;

  // A 16-byte block has 4 offset bits; 8 halfwords need a 3-bit slot index.
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_BITS     = 3;

  // The counters need one extra bit so the issue counter can rest at 8.
  localparam int CNT_W = WORD_IDX_BITS + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage : cache_fill_fsm_pkg

`default_nettype wire

// File: rtl/cache_fill_fsm_dff.sv
// ============================================================================
// Module  : cache_fill_fsm_dff
// Purpose : Generic register cell with load enable and asynchronous
//           active-low clear to zero.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous clear, active low
//           en_i  - load enable
//           d_i   - data in
//           q_o   - registered data out
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm_dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : cache_fill_fsm_dff

`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
// ============================================================================
// Module  : cache_fill_fsm_fill_counter
// Purpose : Small up-counter with enable and synchronous clear, used to track
//           words issued to memory and words returned from memory.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous clear, active low
//           en_i  - count up by one
//           clr_i - synchronous clear (wins over en_i)
//           cnt_o - current count
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm_fill_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule : cache_fill_fsm_fill_counter

`default_nettype wire

// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module  : cache_fill_fsm
// Purpose : Cache miss fill engine. On a miss it issues one halfword read per
//           cycle for the whole 16-byte block to a pipelined memory and steers
//           the returning words into the data array, writing the tag with the
//           last word.
// Ports   : clk               - clock, rising edge
//           rst               - asynchronous reset, active low
//           miss_detected     - level miss request, held until fill done
//           miss_address      - byte address that missed
//           memory_data_valid - returning memory word valid this cycle
//           fsm_busy          - fill in progress (stalls the pipeline)
//           mem_read_en       - issue a read at memory_address this cycle
//           memory_address    - even byte address of the word being read
//           write_data_array  - write returning word into the data array
//           write_tag_array   - write tag/valid (with the last word)
//           word_index        - slot within the block for write_data_array
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic                     memory_data_valid,
  output logic                     fsm_busy,
  output logic                     mem_read_en,
  output logic [ADDR_W-1:0]        memory_address,
  output logic                     write_data_array,
  output logic                     write_tag_array,
  output logic [WORD_IDX_BITS-1:0] word_index
);

  localparam int TAG_W = ADDR_W - BLOCK_OFFSET_BITS;

  fill_state_e        state_q;
  fill_state_e        state_d;
  logic               state_bit_q;
  logic [TAG_W-1:0]   base_q;
  logic               start_fill;
  logic               issue_en;
  logic               recv_en;
  logic               cnt_clr;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   recv_cnt;

  // The block offset of the missing address never matters: reads always
  // start at the block base.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[BLOCK_OFFSET_BITS-1:0];

  cache_fill_fsm_dff #(.WIDTH(1)) u_state_reg (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (1'b1),
    .d_i   (state_d),
    .q_o   (state_bit_q)
  );

  assign state_q = fill_state_e'(state_bit_q);

  // Only the tag/index part of the block base is kept; the low bits are
  // supplied by the issue counter, so there is never a carry out of the block.
  cache_fill_fsm_dff #(.WIDTH(TAG_W)) u_base_reg (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (start_fill),
    .d_i   (miss_address[ADDR_W-1:BLOCK_OFFSET_BITS]),
    .q_o   (base_q)
  );

  cache_fill_fsm_fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (issue_en),
    .clr_i (cnt_clr),
    .cnt_o (issue_cnt)
  );

  cache_fill_fsm_fill_counter #(.WIDTH(CNT_W)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (recv_en),
    .clr_i (cnt_clr),
    .cnt_o (recv_cnt)
  );

  // Outputs are decoded from state and counters in the same cycle so the
  // first read goes out with the miss itself. Everything is gated by reset so
  // no strobe or busy can leak while rst is held low.
  always_comb begin
    state_d          = state_q;
    start_fill       = 1'b0;
    issue_en         = 1'b0;
    recv_en          = 1'b0;
    cnt_clr          = 1'b0;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_index       = '0;

    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          fsm_busy = miss_detected;
          if (miss_detected) begin
            start_fill     = 1'b1;
            issue_en       = 1'b1;
            mem_read_en    = 1'b1;
            memory_address = {miss_address[ADDR_W-1:BLOCK_OFFSET_BITS],
                              {BLOCK_OFFSET_BITS{1'b0}}};
            state_d        = ST_FILL;
          end
        end

        ST_FILL: begin
          fsm_busy = 1'b1;
          // Issue counter saturates at WORDS_PER_BLOCK: no further reads.
          if (issue_cnt < CNT_W'(WORDS_PER_BLOCK)) begin
            issue_en       = 1'b1;
            mem_read_en    = 1'b1;
            memory_address = {base_q, issue_cnt[WORD_IDX_BITS-1:0], 1'b0};
          end
          if (memory_data_valid) begin
            recv_en          = 1'b1;
            write_data_array = 1'b1;
            word_index       = recv_cnt[WORD_IDX_BITS-1:0];
            if (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
              write_tag_array = 1'b1;
              cnt_clr         = 1'b1;
              state_d         = ST_IDLE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule : cache_fill_fsm

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module  : tb_cache_fill_fsm
// Purpose : Self-checking bench for cache_fill_fsm. A transaction-level model
//           (queue of expected read addresses plus a received-word count)
//           predicts every output each cycle; a delay line models the
//           pipelined memory returning data MEM_LATENCY cycles after a read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;

  localparam int MEM_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  word_index;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .word_index        (word_index)
  );

  logic [22:0] obs;
  assign obs = {fsm_busy, mem_read_en, memory_address,
                write_data_array, write_tag_array, word_index};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_active;
  logic [15:0] m_q[$];
  int          m_writes;
  logic [22:0] exp_v;

  // Memory model state
  logic [MEM_LATENCY-1:0] dly;
  int                     pending;
  int                     mode;     // 0: fixed latency, 1: alternate-cycle returns
  bit                     gap_ph;

  function automatic string fmt(input logic [22:0] v);
    return $sformatf("busy=%b rd=%b addr=%h wda=%b wta=%b idx=%0d",
                     v[22], v[21], v[20:5], v[4], v[3], v[2:0]);
  endfunction

  function automatic logic [22:0] model_out();
    logic b, r, w, t;
    logic [15:0] a;
    logic [2:0]  i;
    b = 1'b0; r = 1'b0; w = 1'b0; t = 1'b0; a = '0; i = '0;
    if (rst) begin
      if (!m_active) begin
        b = miss_detected;
        if (miss_detected) begin
          r = 1'b1;
          a = miss_address & 16'hFFF0;
        end
      end else begin
        b = 1'b1;
        if (m_q.size() > 0) begin
          r = 1'b1;
          a = m_q[0];
        end
        if (memory_data_valid) begin
          w = 1'b1;
          i = m_writes[2:0];
          t = (m_writes == 7);
        end
      end
    end
    return {b, r, a, w, t, i};
  endfunction

  // Called at posedge+1: apply inputs, settle to negedge, predict outputs.
  task automatic drive(input logic r, input logic m, input logic [15:0] a,
                       input logic extra);
    logic arr, v;
    arr = dly[MEM_LATENCY-1];
    v   = 1'b0;
    if (mode == 0) begin
      v = arr;
    end else begin
      pending += int'(arr);
      if (pending > 0 && gap_ph) begin
        v = 1'b1;
        pending--;
      end
      gap_ph = !gap_ph;
    end
    rst               = r;
    miss_detected     = m;
    miss_address      = a;
    memory_data_valid = v | extra;
    @(negedge clk);
    exp_v = model_out();
  endtask

  // Advance the model and the memory pipe across the rising edge.
  task automatic advance();
    logic [15:0] b;
    dly = {dly[MEM_LATENCY-2:0], exp_v[21]};
    if (!rst) begin
      m_active = 1'b0;
      m_q.delete();
      m_writes = 0;
    end else if (!m_active) begin
      if (miss_detected) begin
        m_active = 1'b1;
        m_q.delete();
        b = miss_address & 16'hFFF0;
        for (int k = 1; k < 8; k++) m_q.push_back(b + 16'(2 * k));
      end
    end else begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (memory_data_valid) begin
        m_writes++;
        if (m_writes == 8) begin
          m_active = 1'b0;
          m_writes = 0;
          m_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode = 0; dly = '0; pending = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'($urandom), 16'($urandom), 1'($urandom));
      n_cmp++;
      if (obs !== 23'd0) begin
        n_bad++;
        $display("FAIL reset_held c%0d: got %s want all zero", c, fmt(obs));
      end
      advance();
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    n_cmp++;
    if (obs !== exp_v || fsm_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got %s want %s", fmt(obs), fmt(exp_v));
    end
    advance();
  endtask

  task automatic test_single_miss();
    int busy_n = 0, tag_n = 0, wr_n = 0;
    bit done = 0;
    mode = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      drive(1'b1, (c == 0) || m_active, 16'h1236, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL single_miss c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      busy_n += int'(fsm_busy);
      tag_n  += int'(write_tag_array);
      wr_n   += int'(write_data_array);
      advance();
      if (!m_active) done = 1;
    end
    n_cmp++;
    if (!done || busy_n != 12 || tag_n != 1 || wr_n != 8) begin
      n_bad++;
      $display("FAIL single_miss_totals: got done=%0d busy=%0d tag=%0d wr=%0d want 1/12/1/8",
               done, busy_n, tag_n, wr_n);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 16'h1236, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL single_idle c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      advance();
    end
  endtask

  task automatic test_addr_change();
    int stray = 0;
    bit done = 0;
    mode = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      drive(1'b1, (c == 0) || m_active, (c >= 3) ? 16'h8000 : 16'h1236, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL addr_change c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      if (mem_read_en && memory_address[15:4] != 12'h123) stray++;
      advance();
      if (!m_active) done = 1;
    end
    n_cmp++;
    if (!done || stray != 0) begin
      n_bad++;
      $display("FAIL addr_change_totals: got done=%0d foreign_reads=%0d want 1/0", done, stray);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 16'h8000, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL addr_change_idle c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      advance();
    end
  endtask

  task automatic test_gapped();
    int tag_n = 0, wr_n = 0;
    bit done = 0;
    mode = 1; pending = 0; gap_ph = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      drive(1'b1, (c == 0) || m_active, 16'h5A5A, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL gapped c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      tag_n += int'(write_tag_array);
      wr_n  += int'(write_data_array);
      advance();
      if (!m_active) done = 1;
    end
    n_cmp++;
    if (!done || tag_n != 1 || wr_n != 8) begin
      n_bad++;
      $display("FAIL gapped_totals: got done=%0d tag=%0d wr=%0d want 1/1/8", done, tag_n, wr_n);
    end
    mode = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 16'h5A5A, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL gapped_idle c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    int fills = 0, idle_n = 0, zero_rd = 0;
    logic [15:0] last_rd = '0;
    bit was;
    mode = 0;
    for (int c = 0; c < 80 && fills < 2; c++) begin
      drive(1'b1, 1'b1, (fills == 0) ? 16'h2468 : 16'hFFF8, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      if (!fsm_busy) idle_n++;
      if (mem_read_en) begin
        last_rd = memory_address;
        if (memory_address == 16'h0000) zero_rd++;
      end
      was = m_active;
      advance();
      if (was && !m_active) fills++;
    end
    n_cmp++;
    if (fills != 2 || idle_n != 0 || zero_rd != 0 || last_rd !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL back_to_back_totals: got fills=%0d idle=%0d zero_rd=%0d last=%h want 2/0/0/fffe",
               fills, idle_n, zero_rd, last_rd);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 16'hFFF8, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back_idle c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_fill();
    int wr_after = 0;
    mode = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 16'h3C7E, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL rst_mid_pre c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      advance();
    end
    drive(1'b0, 1'b1, 16'h3C7E, 1'b0);
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL rst_mid_assert: got %s want all zero", fmt(obs));
    end
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, 16'h3C7E, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL rst_mid_post c%0d: got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      wr_after += int'(write_data_array) + int'(write_tag_array) + int'(fsm_busy);
      advance();
    end
    n_cmp++;
    if (wr_after != 0) begin
      n_bad++;
      $display("FAIL rst_mid_stray: got %0d strobes/busy want 0", wr_after);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit done;
    for (int f = 0; f < 8; f++) begin
      mode    = int'($urandom_range(0, 1));
      pending = 0;
      gap_ph  = 1'($urandom);
      a       = 16'($urandom);
      done    = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        drive(1'b1, (c == 0) || m_active,
              ((c > 0) && ($urandom_range(0, 3) == 0)) ? 16'($urandom) : a, 1'b0);
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL random f%0d c%0d: got %s want %s", f, c, fmt(obs), fmt(exp_v));
        end
        advance();
        if (!m_active) done = 1;
      end
      n_cmp++;
      if (!done) begin
        n_bad++;
        $display("FAIL random_timeout f%0d: got no completion want completion", f);
      end
      mode = 0;
      for (int c = 0; c < 5 + int'($urandom_range(0, 3)); c++) begin
        drive(1'b1, 1'b0, 16'($urandom), 1'($urandom));
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL random_idle f%0d c%0d: got %s want %s", f, c, fmt(obs), fmt(exp_v));
        end
        advance();
      end
    end
  endtask

  initial begin
    rst = 1'b0; miss_detected = 1'b0; miss_address = '0; memory_data_valid = 1'b0;
    m_active = 1'b0; m_writes = 0; dly = '0; pending = 0; mode = 0; gap_ph = 1'b0;
    exp_v = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_miss();
    test_addr_change();
    test_gapped();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cache_fill_fsm

`default_nettype wire
